// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: byte-wide RAM plus memory-mapped UART rx holding register and tx FIFO for a soft CPU.
// Optional feature macro CYCLE_COUNTER_EN adds a 32-bit cycle counter readable through a snapshot at 0x30004..0x30007.
module cpu_mem_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_DEPTH       = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_stop,
  output logic        tx_overflow
);

  localparam int PTR_W     = $clog2(TX_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int RAM_BYTES = 1 << RAM_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TX_DEPTH);
  localparam logic [CNT_W-1:0] NEAR_C  = CNT_W'(TX_DEPTH - 2);

  logic       unused_addr_bits;
  logic       io_sel;
  logic       is_data;
  logic       is_stop;
  logic       rd_cyc;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;

  assign unused_addr_bits = ^mem_a[31:18];
  assign io_sel  = (mem_a[17:16] == 2'b11);
  assign is_data = io_sel && (mem_a[15:0] == 16'h0000);
  assign is_stop = io_sel && (mem_a[15:0] == 16'h0004);
  assign rd_cyc  = !mem_wr;
  assign ram_idx = mem_a[RAM_ADDR_WIDTH-1:0];

  // RAM: write-first is not needed because a read of a just-written byte happens a cycle later
  logic [7:0] ram [RAM_BYTES];
  logic [7:0] ram_q;

  always_ff @(posedge clk_in) begin
    if (mem_wr && !io_sel) ram[ram_idx] <= mem_wdata;
    if (rd_cyc) ram_q <= ram[ram_idx];
  end

  // rx holding register; rx_q is kept at zero while empty
  logic       rx_full_q;
  logic [7:0] rx_q;
  logic       rx_pop;

  assign rx_pop   = is_data && rd_cyc && rx_full_q;
  assign rx_ready = !rx_full_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_full_q <= 1'b0;
      rx_q      <= 8'h00;
    end else if (rx_pop) begin
      rx_full_q <= 1'b0;
      rx_q      <= 8'h00;
    end else if (rx_valid && !rx_full_q) begin
      rx_full_q <= 1'b1;
      rx_q      <= rx_data;
    end
  end

`ifdef CYCLE_COUNTER_EN
  logic [31:0] cyc_q;
  logic [31:0] snap_q;
  logic        is_ctr;

  assign is_ctr = io_sel && (mem_a[15:2] == 14'h0001);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cyc_q  <= 32'h0;
      snap_q <= 32'h0;
    end else begin
      cyc_q <= cyc_q + 32'h1;
      if (is_ctr && rd_cyc && (mem_a[1:0] == 2'b00)) snap_q <= cyc_q;
    end
  end
`endif

  // I/O read mux; byte 0 of the counter comes straight from the live counter as it is snapshotted
  logic [7:0] io_rdata_d;

  always_comb begin
    io_rdata_d = 8'h00;
    if (is_data) begin
      io_rdata_d = rx_full_q ? rx_q : 8'h00;
    end
`ifdef CYCLE_COUNTER_EN
    else if (is_ctr) begin
      case (mem_a[1:0])
        2'b00:   io_rdata_d = cyc_q[7:0];
        2'b01:   io_rdata_d = snap_q[15:8];
        2'b10:   io_rdata_d = snap_q[23:16];
        default: io_rdata_d = snap_q[31:24];
      endcase
    end
`endif
  end

  logic       rd_io_q;
  logic [7:0] io_rdata_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_io_q    <= 1'b1;
      io_rdata_q <= 8'h00;
    end else if (rd_cyc) begin
      rd_io_q    <= io_sel;
      io_rdata_q <= io_rdata_d;
    end
  end

  assign mem_rdata = rd_io_q ? io_rdata_q : ram_q;

  // tx FIFO: a pop frees a slot in the same cycle, so push+pop is legal even when full
  logic [7:0]       fifo_q [TX_DEPTH];
  logic [PTR_W-1:0] wptr_q;
  logic [PTR_W-1:0] rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stop_q;
  logic             ovf_q;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic [7:0]       push_byte;

  assign push_req  = mem_wr && ((is_data && (mem_wdata != 8'h00)) || is_stop);
  assign push_byte = is_stop ? 8'h00 : mem_wdata;
  assign pop       = tx_valid && tx_ready;
  assign push_ok   = push_req && ((cnt_q != DEPTH_C) || pop);

  always_ff @(posedge clk_in) begin
    if (push_ok) fifo_q[wptr_q] <= push_byte;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      stop_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push_ok && pop) cnt_q <= cnt_q - 1'b1;
      if (push_req && !push_ok) ovf_q  <= 1'b1;
      if (mem_wr && is_stop)    stop_q <= 1'b1;
    end
  end

  assign tx_valid       = (cnt_q != '0);
  assign tx_data        = fifo_q[rptr_q];
  assign io_buffer_full = (cnt_q >= NEAR_C);
  assign prog_stop      = stop_q;
  assign tx_overflow    = ovf_q;

endmodule
